bus_grant_scheduler: RTL and testbench
======================================

// Module: bus_grant_scheduler
// PURPOSE
//  Grant engine for the 4-client shared server bus. Samples client requests, picks one
//  client (strict priority or round robin, with starvation aging), and drives srv_rq.
//  Holds the grant until srv_ack or a timeout, then reports completion. The bus mux
//  steers address/data using grant/grant_idx.
// PARAMETERS
//  STARVE_LIMIT    8   wait cycles before a requester is force-promoted; 0 = aging off
//  TIMEOUT_CYCLES  16  max BUSY cycles without srv_ack before abort; 0 = timeout off
//  CNT_WIDTH       5   width of wait/timeout counters; must hold max(STARVE_LIMIT,TIMEOUT_CYCLES)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  sched_mode   in   1  0 = strict priority, 1 = round robin
//  client_rq    in   4  request per client; bit0 = client_1 ... bit3 = client_4
//  srv_ack      in   1  server completion strobe
//  srv_rq       out  1  request to server, high for the whole BUSY state
//  grant        out  4  one-hot grant; 0 when no client owns the bus
//  grant_idx    out  2  index of the granted client; valid while grant != 0
//  done         out  1  1-cycle pulse: transaction completed by srv_ack
//  done_idx     out  2  client index that completed; valid with done or timeout_err
//  timeout_err  out  1  1-cycle pulse: transaction aborted by timeout
// BEHAVIOUR
//  Reset: state=IDLE; srv_rq, grant, grant_idx, done, done_idx, timeout_err = 0.
//   All wait counters = 0. RR pointer last = 3, so the first RR winner is client 0.
//  FSM IDLE -> BUSY -> RELEASE -> IDLE. All outputs are registered.
//  IDLE: if client_rq != 0, choose a winner (below) and register grant/grant_idx.
//   sched_mode is sampled here only. Set srv_rq=1 and enter BUSY next cycle.
//   Latency: rq seen in cycle N -> grant and srv_rq high in cycle N+1.
//  Winner selection, evaluated in order:
//   1) starved: any client with wait_cnt == STARVE_LIMIT (limit != 0); lowest index wins.
//   2) strict (mode 0): lowest set index in client_rq.
//   3) RR (mode 1): first set bit scanning last+1, last+2, ... mod 4.
//   On every grant: last := winner, even in strict mode.
//  Wait counters: per client, +1 each cycle while rq=1 and not granted; saturate at
//   STARVE_LIMIT; clear when granted or when rq=0.
//  BUSY: grant and srv_rq are held, independent of client_rq; a transaction cannot be
//   cancelled by the client. tmo_cnt starts at 0 on entry and counts +1 per BUSY cycle
//   without srv_ack.
//   srv_ack=1 -> next cycle RELEASE, done=1, done_idx=grant_idx.
//   No ack and tmo_cnt == TIMEOUT_CYCLES-1 (limit != 0) -> next cycle RELEASE,
//   timeout_err=1, done_idx=grant_idx. srv_rq therefore stays high exactly TIMEOUT_CYCLES.
//   srv_ack in the same cycle as the timeout condition: ack wins (done=1, timeout_err=0).
//  RELEASE: exactly 1 cycle; srv_rq=0, grant=0, grant_idx=0. done/timeout_err are high
//   only in this cycle. Next state IDLE. Turnaround: ack in cycle M -> earliest new
//   grant in cycle M+3.
//  srv_ack while in IDLE or RELEASE: ignored, no output effect.
//  Reset in any state: outputs clear asynchronously; no done/timeout_err for the aborted
//   transaction.
// TESTING
//  1. mode0, rq=4'b1010 -> next cycle grant=4'b0010, idx=1, srv_rq=1; ack after 3 cycles
//     -> done=1, done_idx=1 for 1 cycle, grant=0.
//  2. mode1, rq=4'b1111 held, ack 1 cycle after each grant -> grant_idx 0,1,2,3,0.
//  3. mode0, STARVE_LIMIT=8, rq=4'b0011 held, ack immediate -> client 1 wait_cnt reaches 8
//     and client 1 wins the next arbitration over client 0.
//  4. grant client 2, never ack, TIMEOUT_CYCLES=16 -> srv_rq high exactly 16 cycles, then
//     timeout_err=1, done_idx=2, done=0, grant=0.
//  5. srv_ack on the final timeout cycle -> done=1, timeout_err=0.
//  6. reset pulsed mid-BUSY -> all outputs 0; after release, mode1 with rq=4'b1111 ->
//     first grant_idx=0.

Source files
------------

// File: rtl/bus_grant_scheduler_if.sv
// Bus-side signal bundle of the 4-client grant scheduler.
// The master side drives requests and the server ack. The slave side is the scheduler.
interface bus_grant_scheduler_if;
  logic       sched_mode;
  logic [3:0] client_rq;
  logic       srv_ack;
  logic       srv_rq;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       done;
  logic [1:0] done_idx;
  logic       timeout_err;

  modport master (
    output sched_mode, client_rq, srv_ack,
    input  srv_rq, grant, grant_idx, done, done_idx, timeout_err
  );

  modport slave (
    input  sched_mode, client_rq, srv_ack,
    output srv_rq, grant, grant_idx, done, done_idx, timeout_err
  );
endinterface

// File: rtl/bus_grant_scheduler.sv
// Grant engine for a 4-client shared server bus.
// It picks one requester using one of two policies: strict priority or round robin.
// Aging overrides both policies, so a requester that has waited too long is force-promoted.
// The grant is held while the server works. The transaction ends on srv_ack or on a timeout.
// One RELEASE cycle follows every transaction and carries the completion pulse.
module bus_grant_scheduler #(
  parameter int STARVE_LIMIT   = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input logic                  clk,
  input logic                  reset,
  bus_grant_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam bit                   AGING_ON = (STARVE_LIMIT != 0);
  localparam bit                   TMO_ON   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] STARVE_VAL = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t               state;
  logic                 srv_rq_reg;
  logic [3:0]           grant_reg;
  logic [1:0]           grant_idx_reg;
  logic                 done_reg;
  logic [1:0]           done_idx_reg;
  logic                 timeout_reg;
  logic [1:0]           last;
  logic [CNT_WIDTH-1:0] tmo_cnt;
  logic [CNT_WIDTH-1:0] wait_cnt [4];

  logic [3:0] starved;
  logic [1:0] winner;
  logic [3:0] win_onehot;
  logic       take;
  logic [3:0] granted_now;

  // Return the first set bit of req, scanning from start upward with wrap-around.
  function automatic logic [1:0] first_from(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Winner selection: starved clients first, then the policy chosen by sched_mode.
  always_comb begin
    starved = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      starved[i] = AGING_ON && (wait_cnt[i] == STARVE_VAL) && bus.client_rq[i];
    end
    if (starved != 4'b0000) begin
      winner = first_from(starved, 2'd0);
    end else if (bus.sched_mode) begin
      winner = first_from(bus.client_rq, last + 2'd1);
    end else begin
      winner = first_from(bus.client_rq, 2'd0);
    end
    win_onehot  = 4'b0001 << winner;
    take        = (state == IDLE) && (bus.client_rq != 4'b0000);
    granted_now = grant_reg | (take ? win_onehot : 4'b0000);
  end

  // Per-client aging: count waiting cycles, saturate at the limit, clear on grant or idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.client_rq[i] || granted_now[i]) begin
          wait_cnt[i] <= '0;
        end else if (AGING_ON && (wait_cnt[i] != STARVE_VAL)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Main FSM with registered bus outputs: IDLE -> BUSY -> RELEASE -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      srv_rq_reg    <= 1'b0;
      grant_reg     <= 4'b0000;
      grant_idx_reg <= 2'd0;
      done_reg      <= 1'b0;
      done_idx_reg  <= 2'd0;
      timeout_reg   <= 1'b0;
      last          <= 2'd3;
      tmo_cnt       <= '0;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            grant_reg     <= win_onehot;
            grant_idx_reg <= winner;
            last          <= winner;
            srv_rq_reg    <= 1'b1;
            tmo_cnt       <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.srv_ack) begin
            done_reg      <= 1'b1;
            done_idx_reg  <= grant_idx_reg;
            srv_rq_reg    <= 1'b0;
            grant_reg     <= 4'b0000;
            grant_idx_reg <= 2'd0;
            state         <= RELEASE;
          end else if (TMO_ON && (tmo_cnt == TMO_LAST)) begin
            timeout_reg   <= 1'b1;
            done_idx_reg  <= grant_idx_reg;
            srv_rq_reg    <= 1'b0;
            grant_reg     <= 4'b0000;
            grant_idx_reg <= 2'd0;
            state         <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          srv_rq_reg    <= 1'b0;
          grant_reg     <= 4'b0000;
          grant_idx_reg <= 2'd0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.srv_rq      = srv_rq_reg;
  assign bus.grant       = grant_reg;
  assign bus.grant_idx   = grant_idx_reg;
  assign bus.done        = done_reg;
  assign bus.done_idx    = done_idx_reg;
  assign bus.timeout_err = timeout_reg;

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Bench for bus_grant_scheduler (STARVE_LIMIT=8, TIMEOUT_CYCLES=16).
// A table of transactions drives the DUT. Each expected completion is queued when it is driven.
// The queue is popped whenever done or timeout_err pulses.
module tb_bus_grant_scheduler;

  logic clk = 1'b0;
  logic reset;

  bus_grant_scheduler_if bus ();

  bus_grant_scheduler #(
    .STARVE_LIMIT   (8),
    .TIMEOUT_CYCLES (16),
    .CNT_WIDTH      (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [3:0] rq;
    int         ack_at;    // BUSY cycle in which srv_ack is high, -1 = never
    bit         drop;      // drop client_rq right after the grant
    bit         clr;       // one idle cycle with no requests afterwards
    int         exp_idx;
    int         exp_busy;  // cycles srv_rq stays high
    bit         exp_done;  // 1 = done, 0 = timeout_err
  } txn_t;

  typedef struct {
    int idx;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  txn_t tbl[16];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and score any completion pulse against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.done || bus.timeout_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_completion: done=%0b timeout_err=%0b, none expected",
                 bus.done, bus.timeout_err);
      end else begin
        e = exp_q.pop_front();
        check("done", bus.done, e.done);
        check("timeout_err", bus.timeout_err, !e.done);
        check("done_idx", bus.done_idx, e.idx);
      end
    end
  endtask

  task automatic run_txn(input txn_t t, input int n);
    int   busy;
    exp_t e;
    bus.sched_mode = t.mode;
    bus.client_rq  = t.rq;
    bus.srv_ack    = 1'b0;
    check($sformatf("idle_grant[%0d]", n), bus.grant, 0);
    check($sformatf("idle_pulse[%0d]", n), {bus.done, bus.timeout_err}, 0);
    e.idx  = t.exp_idx;
    e.done = t.exp_done;
    exp_q.push_back(e);
    tick();
    check($sformatf("grant[%0d]", n), bus.grant, 32'd1 << t.exp_idx);
    check($sformatf("grant_idx[%0d]", n), bus.grant_idx, t.exp_idx);
    check($sformatf("srv_rq[%0d]", n), bus.srv_rq, 1);
    if (t.drop) bus.client_rq = 4'b0000;
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == t.ack_at) bus.srv_ack = 1'b1;
      tick();
      bus.srv_ack = 1'b0;
      busy++;
      if (!bus.srv_rq) break;
    end
    check($sformatf("busy_len[%0d]", n), busy, t.exp_busy);
    check($sformatf("release_grant[%0d]", n), {bus.grant, bus.grant_idx}, 0);
    tick();
    if (t.clr) begin
      bus.client_rq = 4'b0000;
      tick();
    end
  endtask

  initial begin
    //          mode  rq       ack drop clr idx busy done
    tbl[0]  = '{1'b1, 4'b1111,  0, 0, 0, 0,  1, 1};
    tbl[1]  = '{1'b1, 4'b1111,  0, 0, 0, 1,  1, 1};
    tbl[2]  = '{1'b1, 4'b1111,  0, 0, 0, 2,  1, 1};
    tbl[3]  = '{1'b1, 4'b1111,  0, 0, 0, 3,  1, 1};
    tbl[4]  = '{1'b1, 4'b1111,  0, 0, 1, 0,  1, 1};
    tbl[5]  = '{1'b0, 4'b1010,  3, 0, 1, 1,  4, 1};
    tbl[6]  = '{1'b0, 4'b0011,  0, 0, 0, 0,  1, 1};
    tbl[7]  = '{1'b0, 4'b0011,  0, 0, 0, 0,  1, 1};
    tbl[8]  = '{1'b0, 4'b0011,  0, 0, 0, 0,  1, 1};
    tbl[9]  = '{1'b0, 4'b0011,  0, 0, 0, 1,  1, 1};
    tbl[10] = '{1'b0, 4'b0011,  0, 0, 1, 0,  1, 1};
    tbl[11] = '{1'b0, 4'b0100, -1, 1, 0, 2, 16, 0};
    tbl[12] = '{1'b1, 4'b0100, 15, 0, 1, 2, 16, 1};
    tbl[13] = '{1'b1, 4'b1001,  1, 0, 0, 3,  2, 1};
    tbl[14] = '{1'b1, 4'b1001,  1, 0, 1, 0,  2, 1};
    tbl[15] = '{1'b0, 4'b1100,  2, 0, 1, 2,  3, 1};

    reset          = 1'b1;
    bus.sched_mode = 1'b0;
    bus.client_rq  = 4'b0000;
    bus.srv_ack    = 1'b0;
    tick();
    tick();
    check("rst_srv_rq", bus.srv_rq, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_grant_idx", bus.grant_idx, 0);
    check("rst_done", bus.done, 0);
    check("rst_done_idx", bus.done_idx, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    reset = 1'b0;
    tick();

    for (int n = 0; n < 16; n++) run_txn(tbl[n], n);

    // srv_ack while idle must not start or complete anything.
    bus.client_rq = 4'b0000;
    bus.srv_ack   = 1'b1;
    tick();
    tick();
    check("idle_ack_srv_rq", bus.srv_rq, 0);
    check("idle_ack_grant", bus.grant, 0);
    check("idle_ack_pulse", {bus.done, bus.timeout_err}, 0);
    bus.srv_ack = 1'b0;
    tick();

    // Reset mid-BUSY: outputs clear at once and the aborted transaction never completes.
    bus.sched_mode = 1'b1;
    bus.client_rq  = 4'b1111;
    tick();
    check("pre_rst_grant_idx", bus.grant_idx, 3);
    check("pre_rst_srv_rq", bus.srv_rq, 1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_srv_rq", bus.srv_rq, 0);
    check("async_rst_grant", bus.grant, 0);
    check("async_rst_grant_idx", bus.grant_idx, 0);
    check("async_rst_done_idx", bus.done_idx, 0);
    check("async_rst_pulse", {bus.done, bus.timeout_err}, 0);
    tick();
    reset = 1'b0;
    begin
      exp_t e;
      e.idx  = 0;
      e.done = 1'b1;
      exp_q.push_back(e);
    end
    tick();
    check("post_rst_grant", bus.grant, 4'b0001);
    check("post_rst_grant_idx", bus.grant_idx, 0);
    bus.srv_ack = 1'b1;
    tick();
    bus.srv_ack   = 1'b0;
    bus.client_rq = 4'b0000;
    check("post_rst_release", bus.srv_rq, 0);
    tick();
    tick();

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
